// File: rtl/cfgparm_pkg.sv
// Shared types and helpers for the configuration-parameter frame receiver.
// Byte-order constants and the per-byte lane mapping live here.
package cfgparm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK
  } state_t;

  localparam int ORD_LEGACY = 0;
  localparam int ORD_BE     = 1;
  localparam int ORD_LE     = 2;

  // Legacy order swaps the two bytes inside each 16-bit half.
  function automatic logic [4:0] lane_of(
    input logic [1:0] byte_idx,
    input int         order
  );
    logic [4:0] off;
    off = 5'd0;
    unique case (1'b1)
      order == ORD_BE: off = {~byte_idx, 3'b000};
      order == ORD_LE: off = {byte_idx, 3'b000};
      default:         off = {byte_idx ^ 2'b01, 3'b000};
    endcase
    return off;
  endfunction

endpackage

// File: rtl/cfgparm_chk_acc.sv
// 8-bit running sum over the payload bytes of a frame.
// A frame is good when its checksum byte equals the inverted sum.
module cfgparm_chk_acc (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic       acc,
  input  logic [7:0] data,
  input  logic [7:0] chk,
  output logic       match
);

  logic [7:0] sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= 8'h00;
    end else if (clr) begin
      sum <= 8'h00;
    end else if (load) begin
      sum <= data;
    end else if (acc) begin
      sum <= sum + data;
    end
  end

  assign match = (chk == ~sum);

endmodule

// File: rtl/cfgparm_frm_rx.sv
// Deserialises a byte frame into PARAM_NUM 32-bit words held in a shadow
// store; the words are committed only for a full-length, good-sum frame.
import cfgparm_pkg::*;

module cfgparm_frm_rx #(
  parameter int PARAM_NUM  = 6,
  parameter int BYTE_ORDER = 0,
  parameter int CHK_EN     = 1
) (
  input  logic                   clk_sys,
  input  logic                   rst_sys_n,
  input  logic                   cfg_param_dval,
  input  logic [7:0]             slink_cfg_data,
  output logic [PARAM_NUM*32-1:0] cfg_param,
  output logic                   cfg_upd_pls,
  output logic                   cfg_err_len,
  output logic                   cfg_err_chk,
  output logic [7:0]             cfg_err_cnt
);

  localparam int PAY = PARAM_NUM * 4;
  localparam int FRM = PAY + CHK_EN;
  localparam int CW  = $clog2(FRM + 2);
  localparam int WW  = (PARAM_NUM > 1) ? $clog2(PARAM_NUM) : 1;

  localparam logic [CW-1:0] PAY_C = CW'(PAY);
  localparam logic [CW-1:0] FRM_C = CW'(FRM);
  localparam logic [CW-1:0] OVR_C = CW'(FRM + 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] wr_idx;
  logic [WW-1:0] wr_word;
  logic [4:0]    wr_lane;
  logic [31:0]   shadow_q [PARAM_NUM];
  logic [7:0]    chk_q;

  logic wr_en;
  logic acc_ld;
  logic acc_add;
  logic acc_clr;
  logic chk_ld;
  logic chk_match;
  logic commit;
  logic err_len;
  logic err_chk;

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_idx  = '0;
    wr_en   = 1'b0;
    acc_ld  = 1'b0;
    acc_add = 1'b0;
    acc_clr = 1'b0;
    chk_ld  = 1'b0;
    commit  = 1'b0;
    err_len = 1'b0;
    err_chk = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_param_dval) begin
          state_d = ST_RECV;
          cnt_d   = CW'(1);
          wr_en   = 1'b1;
          acc_ld  = 1'b1;
        end
      end
      ST_RECV: begin
        if (cfg_param_dval) begin
          wr_idx = cnt_q;
          if (cnt_q < PAY_C) begin
            wr_en   = 1'b1;
            acc_add = 1'b1;
          end else if (CHK_EN != 0 && cnt_q == PAY_C) begin
            chk_ld = 1'b1;
          end
          if (cnt_q != OVR_C) begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (cnt_q != FRM_C) begin
          err_len = 1'b1;
        end else if (CHK_EN != 0 && !chk_match) begin
          err_chk = 1'b1;
        end else begin
          commit = 1'b1;
        end
        // A strobe here is byte 0 of the next frame.
        if (cfg_param_dval) begin
          state_d = ST_RECV;
          cnt_d   = CW'(1);
          wr_en   = 1'b1;
          acc_ld  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          acc_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_word = WW'(wr_idx >> 2);
  assign wr_lane = lane_of(wr_idx[1:0], BYTE_ORDER);

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      for (int w = 0; w < PARAM_NUM; w++) begin
        shadow_q[w] <= '0;
      end
    end else if (wr_en) begin
      shadow_q[wr_word][wr_lane +: 8] <= slink_cfg_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      chk_q <= 8'h00;
    end else if (chk_ld) begin
      chk_q <= slink_cfg_data;
    end
  end

  cfgparm_chk_acc u_chk_acc (
    .clk   (clk_sys),
    .rst_n (rst_sys_n),
    .clr   (acc_clr),
    .load  (acc_ld),
    .acc   (acc_add),
    .data  (slink_cfg_data),
    .chk   (chk_q),
    .match (chk_match)
  );

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      cfg_param   <= '0;
      cfg_upd_pls <= 1'b0;
      cfg_err_len <= 1'b0;
      cfg_err_chk <= 1'b0;
      cfg_err_cnt <= 8'h00;
    end else begin
      cfg_upd_pls <= commit;
      cfg_err_len <= err_len;
      cfg_err_chk <= err_chk;
      if (commit) begin
        for (int w = 0; w < PARAM_NUM; w++) begin
          cfg_param[w*32 +: 32] <= shadow_q[w];
        end
      end
      if ((err_len || err_chk) && cfg_err_cnt != 8'hFF) begin
        cfg_err_cnt <= cfg_err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cfgparm_frm_rx.sv
// Bench for cfgparm_frm_rx: three byte orders driven by one stream,
// checked against table constants and a frame-level reference model.
module tb_cfgparm_frm_rx;

  localparam int P   = 6;
  localparam int PAY = P * 4;
  localparam int FRM = PAY + 1;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int             kind;
    logic [P*32-1:0] pa;
    logic [P*32-1:0] pb;
    logic [P*32-1:0] pc;
    logic [7:0]     ec;
  } exp_t;

  typedef struct {
    logic [31:0] p0;
    int          len;
    logic [7:0]  x;
    logic [31:0] el;
    logic [31:0] eb;
    logic [31:0] ee;
    logic [7:0]  ec;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dval = 1'b0;
  logic [7:0]      data = 8'h00;
  logic [P*32-1:0] prm [3];
  logic            upd [3];
  logic            elen [3];
  logic            echk [3];
  logic [7:0]      ecnt [3];

  always #5 clk = ~clk;

  cfgparm_frm_rx #(.PARAM_NUM(P), .BYTE_ORDER(0), .CHK_EN(1)) d0 (
    .clk_sys(clk), .rst_sys_n(rst_n), .cfg_param_dval(dval),
    .slink_cfg_data(data), .cfg_param(prm[0]), .cfg_upd_pls(upd[0]),
    .cfg_err_len(elen[0]), .cfg_err_chk(echk[0]), .cfg_err_cnt(ecnt[0]));

  cfgparm_frm_rx #(.PARAM_NUM(P), .BYTE_ORDER(1), .CHK_EN(1)) d1 (
    .clk_sys(clk), .rst_sys_n(rst_n), .cfg_param_dval(dval),
    .slink_cfg_data(data), .cfg_param(prm[1]), .cfg_upd_pls(upd[1]),
    .cfg_err_len(elen[1]), .cfg_err_chk(echk[1]), .cfg_err_cnt(ecnt[1]));

  cfgparm_frm_rx #(.PARAM_NUM(P), .BYTE_ORDER(2), .CHK_EN(1)) d2 (
    .clk_sys(clk), .rst_sys_n(rst_n), .cfg_param_dval(dval),
    .slink_cfg_data(data), .cfg_param(prm[2]), .cfg_upd_pls(upd[2]),
    .cfg_err_len(elen[2]), .cfg_err_chk(echk[2]), .cfg_err_cnt(ecnt[2]));

  int n_pass = 0;
  int n_chk  = 0;

  logic [P*32-1:0] mp [3];
  logic [7:0]      m_ec;
  exp_t            expq[$];

  task automatic check(input string nm, input logic [P*32-1:0] act,
                       input logic [P*32-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Word value from its four frame bytes, as each order defines it.
  function automatic logic [31:0] mword(input logic [7:0] b0, b1, b2, b3,
                                        input int ord);
    case (ord)
      1:       return {b0, b1, b2, b3};
      2:       return {b3, b2, b1, b0};
      default: return {b2, b3, b0, b1};
    endcase
  endfunction

  function automatic bq_t build(input logic [31:0] p0, input int len,
                                input logic [7:0] x, input bit rnd);
    bq_t q;
    logic [7:0] s;
    logic [7:0] b;
    s = 8'h00;
    for (int i = 0; i < PAY; i++) begin
      if (rnd) b = 8'($urandom_range(0, 255));
      else if (i < 4) b = p0[31 - 8*i -: 8];
      else b = 8'h00;
      q.push_back(b);
      s = s + b;
    end
    q.push_back(~s ^ x);
    while (q.size() < len) q.push_back(8'h00);
    while (q.size() > len) void'(q.pop_back());
    return q;
  endfunction

  task automatic finish_frame(input bq_t fr);
    exp_t e;
    logic [7:0] s;
    s = 8'h00;
    if (fr.size() != FRM) begin
      e.kind = 2;
    end else begin
      for (int i = 0; i < PAY; i++) s = s + fr[i];
      e.kind = (fr[PAY] == ~s) ? 1 : 4;
    end
    if (e.kind == 1) begin
      for (int o = 0; o < 3; o++)
        for (int w = 0; w < P; w++)
          mp[o][w*32 +: 32] = mword(fr[4*w], fr[4*w+1], fr[4*w+2],
                                    fr[4*w+3], o);
    end else if (m_ec != 8'hFF) begin
      m_ec = m_ec + 8'd1;
    end
    e.pa = mp[0];
    e.pb = mp[1];
    e.pc = mp[2];
    e.ec = m_ec;
    expq.push_back(e);
  endtask

  task automatic send_frame(input bq_t fr, input int gap);
    foreach (fr[i]) begin
      @(negedge clk);
      dval = 1'b1;
      data = fr[i];
    end
    @(negedge clk);
    dval = 1'b0;
    data = 8'h00;
    finish_frame(fr);
    repeat (gap - 1) @(negedge clk);
  endtask

  logic [2:0]      kv [3];
  logic            prev_any = 1'b0;
  exp_t            me;
  logic [P*32-1:0] ep [3];

  always @(negedge clk) begin
    for (int o = 0; o < 3; o++) kv[o] = {echk[o], elen[o], upd[o]};
    if (!rst_n) begin
      prev_any = 1'b0;
    end else if (kv[0] != 0 || kv[1] != 0 || kv[2] != 0) begin
      check("pulse_width", prev_any, 0);
      prev_any = 1'b1;
      if (expq.size() == 0) begin
        check("unexpected_pulse", kv[0], 0);
      end else begin
        me = expq.pop_front();
        ep[0] = me.pa;
        ep[1] = me.pb;
        ep[2] = me.pc;
        for (int o = 0; o < 3; o++) begin
          check($sformatf("kind%0d", o), kv[o], me.kind);
          check($sformatf("param%0d", o), prm[o], ep[o]);
          check($sformatf("err_cnt%0d", o), ecnt[o], me.ec);
        end
      end
    end else begin
      prev_any = 1'b0;
    end
  end

  vec_t vt [6];

  initial begin
    bq_t fr;
    vt[0] = '{32'hA1B2C3D4, 25, 8'h00, 32'hC3D4A1B2, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'd0};
    vt[1] = '{32'h00000000, 25, 8'hFF, 32'hC3D4A1B2, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'd1};
    vt[2] = '{32'hA1B2C3D4, 24, 8'h00, 32'hC3D4A1B2, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'd2};
    vt[3] = '{32'h11223344, 30, 8'h00, 32'hC3D4A1B2, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'd3};
    vt[4] = '{32'h55667788,  1, 8'h00, 32'hC3D4A1B2, 32'hA1B2C3D4, 32'hD4C3B2A1, 8'd4};
    vt[5] = '{32'h11223344, 25, 8'h00, 32'h33441122, 32'h11223344, 32'h44332211, 8'd4};

    for (int o = 0; o < 3; o++) mp[o] = '0;
    m_ec = 8'h00;

    repeat (3) @(negedge clk);
    for (int o = 0; o < 3; o++) begin
      check($sformatf("rst_param%0d", o), prm[o], 0);
      check($sformatf("rst_pulses%0d", o), {upd[o], elen[o], echk[o]}, 0);
      check($sformatf("rst_cnt%0d", o), ecnt[o], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send_frame(build(vt[v].p0, vt[v].len, vt[v].x, 1'b0), 4);
      check($sformatf("vec%0d_leg", v), prm[0][31:0], vt[v].el);
      check($sformatf("vec%0d_be", v), prm[1][31:0], vt[v].eb);
      check($sformatf("vec%0d_le", v), prm[2][31:0], vt[v].ee);
      check($sformatf("vec%0d_cnt", v), ecnt[0], vt[v].ec);
    end

    // Back-to-back frames with a single idle cycle between them.
    send_frame(build(32'hDEADBEEF, 25, 8'h00, 1'b0), 1);
    send_frame(build(32'hCAFEF00D, 25, 8'h00, 1'b0), 4);
    check("b2b_be", prm[1][31:0], 32'hCAFEF00D);

    // Reset in the middle of a frame.
    fr = build(32'h01020304, 25, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dval = 1'b1;
      data = fr[i];
    end
    @(negedge clk);
    rst_n = 1'b0;
    dval  = 1'b0;
    #1;
    check("midrst_param", prm[0], 0);
    check("midrst_cnt", ecnt[0], 0);
    for (int o = 0; o < 3; o++) mp[o] = '0;
    m_ec = 8'h00;
    expq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(build(32'h01020304, 25, 8'h00, 1'b0), 4);
    check("postrst_leg", prm[0][31:0], 32'h03040102);

    for (int n = 0; n < 40; n++) begin
      int r;
      int len;
      logic [7:0] x;
      r = $urandom_range(0, 9);
      if (r == 0) len = $urandom_range(1, PAY);
      else if (r == 1) len = $urandom_range(FRM + 1, FRM + 7);
      else len = FRM;
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_frame(build(32'h0, len, x, 1'b1), $urandom_range(1, 3));
    end

    // Drive enough rejected frames to pin the error counter.
    for (int n = 0; n < 260; n++) begin
      send_frame(build(32'h0, 1, 8'h00, 1'b0), 2);
    end

    for (int i = 0; i < 20 && expq.size() != 0; i++) @(negedge clk);
    check("drain", expq.size(), 0);
    check("sat_cnt", ecnt[0], 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
